// File: rtl/msg_streamer.sv
// Streams the fixed message "Hello, World!\r\n" to a UART TX over valid/ready
// each time an idle-state send pulse arrives, with optional idle gaps between bytes.
module msg_streamer #(
  parameter int GAP_CYCLES = 0,
  parameter int MSG_LEN    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       done
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [GAP_W-1:0] gap_cnt;

  function automatic logic [7:0] rom(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       rom = 8'h48;
      1:       rom = 8'h65;
      2:       rom = 8'h6C;
      3:       rom = 8'h6C;
      4:       rom = 8'h6F;
      5:       rom = 8'h2C;
      6:       rom = 8'h20;
      7:       rom = 8'h57;
      8:       rom = 8'h6F;
      9:       rom = 8'h72;
      10:      rom = 8'h6C;
      11:      rom = 8'h64;
      12:      rom = 8'h21;
      13:      rom = 8'h0D;
      14:      rom = 8'h0A;
      default: rom = 8'h00;
    endcase
  endfunction

  // Message FSM; index already points at the next byte while waiting in GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      index    <= '0;
      gap_cnt  <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            state    <= SEND;
            index    <= '0;
            tx_data  <= rom('0);
            tx_valid <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          if (tx_valid && tx_ready) begin
            if (index == LAST_IDX) begin
              state    <= IDLE;
              index    <= '0;
              tx_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              index   <= index + IDX_W'(1);
              tx_data <= rom(index + IDX_W'(1));
            end else begin
              state    <= GAP;
              index    <= index + IDX_W'(1);
              gap_cnt  <= '0;
              tx_valid <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= SEND;
            tx_data  <= rom(index);
            tx_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          index    <= '0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_streamer.sv
// Scoreboard bench for msg_streamer: one instance with no gap, one with a 3-cycle gap,
// directed scenarios followed by randomized send/backpressure traffic.
module tb_msg_streamer;

  localparam int MSG_LEN = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] send;
  logic [1:0] tx_ready;
  logic [1:0] tx_valid;
  logic [1:0] busy;
  logic [1:0] done;
  logic [7:0] tx_data [2];

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 1'b0;

  string msg = "Hello, World!\r\n";

  // Reference model state per instance: bytes left, idle cycles until next byte.
  logic [7:0] exp_q [2][$];
  int  rem      [2];
  int  wait_cyc [2];
  bit  done_exp [2];
  bit  prev_valid [2];
  bit  prev_ready [2];
  logic [7:0] prev_data [2];
  bit  prev_rst = 1'b0;

  always #5 clk = ~clk;

  msg_streamer #(.GAP_CYCLES(0), .MSG_LEN(MSG_LEN)) dut0 (
    .clk(clk), .rst(rst), .send(send[0]), .tx_ready(tx_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .busy(busy[0]), .done(done[0])
  );

  msg_streamer #(.GAP_CYCLES(3), .MSG_LEN(MSG_LEN)) dut1 (
    .clk(clk), .rst(rst), .send(send[1]), .tx_ready(tx_ready[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Monitor + model: compare this cycle's outputs, then advance the model past the edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit exp_valid;
      bit busy_now;
      bit xfer;
      bit done_n;
      logic [7:0] e;
      exp_valid = (rem[k] > 0) && (wait_cyc[k] == 0);
      busy_now  = (rem[k] > 0);
      if (checking) begin
        chk("tx_valid", k, {31'd0, tx_valid[k]}, {31'd0, exp_valid});
        chk("busy", k, {31'd0, busy[k]}, {31'd0, busy_now});
        chk("done", k, {31'd0, done[k]}, {31'd0, done_exp[k]});
        if (prev_rst)
          chk("reset_tx_data", k, {24'd0, tx_data[k]}, 32'h0);
        else if (prev_valid[k] && !prev_ready[k])
          chk("hold_tx_data", k, {24'd0, tx_data[k]}, {24'd0, prev_data[k]});
      end
      done_n = 1'b0;
      xfer   = exp_valid && tx_ready[k] && !rst;
      if (rst) begin
        rem[k]      = 0;
        wait_cyc[k] = 0;
        exp_q[k].delete();
      end else begin
        if (xfer) begin
          e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 8'hxx;
          if (checking) chk("tx_data", k, {24'd0, tx_data[k]}, {24'd0, e});
          rem[k]--;
          if (rem[k] == 0) done_n = 1'b1;
          else wait_cyc[k] = gap_of(k);
        end else if (busy_now && wait_cyc[k] > 0) begin
          wait_cyc[k]--;
        end
        if (send[k] && !busy_now) begin
          rem[k]      = MSG_LEN;
          wait_cyc[k] = 0;
          for (int i = 0; i < MSG_LEN; i++) exp_q[k].push_back(msg[i]);
        end
      end
      done_exp[k]   = done_n;
      prev_valid[k] = tx_valid[k];
      prev_ready[k] = tx_ready[k];
      prev_data[k]  = tx_data[k];
    end
    prev_rst = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; send = 2'b00; tx_ready = 2'b00;
    repeat (2) step();
    rst = 1'b0; checking = 1'b1;

    // Full message, no backpressure.
    tx_ready[0] = 1'b1; send[0] = 1'b1; step(); send[0] = 1'b0;
    repeat (20) step();

    // Backpressure while index 3 is presented.
    send[0] = 1'b1; step(); send[0] = 1'b0;
    repeat (3) step();
    tx_ready[0] = 1'b0; repeat (5) step();
    tx_ready[0] = 1'b1; repeat (20) step();

    // Extra sends at N+3 and N+15 dropped; send held into done cycle restarts.
    send[0] = 1'b1; step(); send[0] = 1'b0;
    repeat (2) step();
    send[0] = 1'b1; step(); send[0] = 1'b0;
    repeat (11) step();
    send[0] = 1'b1; repeat (2) step(); send[0] = 1'b0;
    repeat (20) step();

    // Reset while index 7 is presented, then restart.
    send[0] = 1'b1; step(); send[0] = 1'b0;
    repeat (7) step();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (3) step();
    send[0] = 1'b1; step(); send[0] = 1'b0;
    repeat (20) step();

    // Gap instance: done lands at N+58; send on that cycle restarts.
    tx_ready[1] = 1'b1; send[1] = 1'b1; step(); send[1] = 1'b0;
    repeat (57) step();
    send[1] = 1'b1; step(); send[1] = 1'b0;
    repeat (70) step();

    // Randomized traffic on both instances.
    repeat (800) begin
      for (int k = 0; k < 2; k++) begin
        send[k]     = ($urandom_range(0, 24) == 0);
        tx_ready[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    send = 2'b00; tx_ready = 2'b11;
    repeat (80) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
